// File: rtl/weightbuffer_ctrl_pkg.sv
// Shared types for the ping/pong weight buffer controller.
package weightbuffer_ctrl_pkg;

  localparam int N_BANKS = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_READY,
    ST_FLUSH
  } state_e;

endpackage

// File: rtl/weightbuffer_ctrl_decoder.sv
// Turns the beat counter into a one-hot block save strobe, active only on a handshake.
module weightbuffer_ctrl_decoder #(
  parameter int N_O   = 64,
  parameter int CNT_W = (N_O > 1) ? $clog2(N_O) : 1
) (
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             en_i,
  output logic [N_O-1:0]   onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[cnt_i] = 1'b1;
  end

endmodule

// File: rtl/weightbuffer_ctrl.sv
// Ping/pong weight buffer controller: clears and fills the idle bank one block per beat,
// then swaps it to the compute array once the array has released the other bank.
module weightbuffer_ctrl
  import weightbuffer_ctrl_pkg::*;
#(
  parameter int N_O = 64
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            start_i,
  input  logic [$clog2(N_O+1)-1:0]        num_o_i,
  input  logic                            wvalid_i,
  output logic                            wready_o,
  output logic [N_BANKS-1:0][N_O-1:0]     save_enable_o,
  output logic [N_BANKS-1:0]              flush_o,
  output logic                            compute_bank_o,
  input  logic                            compute_release_i,
  input  logic                            flush_req_i,
  output logic                            load_done_o,
  output logic                            err_o,
  output logic                            busy_o
);

  localparam int CNT_W = (N_O > 1) ? $clog2(N_O) : 1;
  localparam int NUM_W = $clog2(N_O + 1);
  localparam logic [NUM_W-1:0] NUM_MAX = NUM_W'(N_O);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_W-1:0]       num_o_q, num_o_d;
  logic                   load_bank_q, load_bank_d;
  logic                   compute_bank_q, compute_bank_d;
  logic                   compute_busy_q, compute_busy_d;
  logic [N_BANKS-1:0]     flush_q, flush_d;
  logic                   load_done_q, load_done_d;
  logic                   err_q, err_d;

  logic                   handshake;
  logic                   last_beat;
  logic [N_O-1:0]         block_sel;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      num_o_q        <= '0;
      load_bank_q    <= 1'b0;
      compute_bank_q <= 1'b0;
      compute_busy_q <= 1'b0;
      flush_q        <= '0;
      load_done_q    <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      num_o_q        <= num_o_d;
      load_bank_q    <= load_bank_d;
      compute_bank_q <= compute_bank_d;
      compute_busy_q <= compute_busy_d;
      flush_q        <= flush_d;
      load_done_q    <= load_done_d;
      err_q          <= err_d;
    end
  end

  assign last_beat = (NUM_W'(cnt_q) == (num_o_q - NUM_W'(1)));

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    num_o_d        = num_o_q;
    load_bank_d    = load_bank_q;
    compute_bank_d = compute_bank_q;
    compute_busy_d = compute_busy_q;
    err_d          = 1'b0;

    if (compute_release_i) compute_busy_d = 1'b0;

    // A flush request overrides whatever the current state was about to do.
    if (flush_req_i) begin
      state_d        = ST_FLUSH;
      cnt_d          = '0;
      compute_busy_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            if ((num_o_i != '0) && (num_o_i <= NUM_MAX)) begin
              state_d     = ST_CLEAR;
              num_o_d     = num_o_i;
              load_bank_d = ~compute_bank_q;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_CLEAR: begin
          cnt_d   = '0;
          state_d = ST_LOAD;
        end
        ST_LOAD: begin
          if (handshake) begin
            if (last_beat) begin
              cnt_d   = '0;
              state_d = ST_READY;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_READY: begin
          if (!compute_busy_q || compute_release_i) begin
            compute_bank_d = ~compute_bank_q;
            compute_busy_d = 1'b1;
            state_d        = ST_IDLE;
          end
        end
        ST_FLUSH: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Registered strobes are derived from the state being entered so they line up with it.
  always_comb begin
    flush_d = '0;
    if (state_d == ST_FLUSH) flush_d = '1;
    else if (state_d == ST_CLEAR) flush_d[load_bank_d] = 1'b1;
    load_done_d = (state_q == ST_LOAD) && (state_d == ST_READY);
  end

  always_comb begin
    wready_o      = (state_q == ST_LOAD) && !flush_req_i;
    handshake     = wready_o && wvalid_i;
    busy_o        = (state_q != ST_IDLE);
    save_enable_o = '0;
    save_enable_o[load_bank_q] = block_sel;
  end

  weightbuffer_ctrl_decoder #(
    .N_O   (N_O),
    .CNT_W (CNT_W)
  ) u_decoder (
    .cnt_i    (cnt_q),
    .en_i     (handshake),
    .onehot_o (block_sel)
  );

  assign flush_o        = flush_q;
  assign load_done_o    = load_done_q;
  assign err_o          = err_q;
  assign compute_bank_o = compute_bank_q;

endmodule

// File: tb/tb_weightbuffer_ctrl.sv
// Directed bench for weightbuffer_ctrl with N_O=4: loads, back-pressure from compute,
// sparse beats, flushes, illegal counts and asynchronous reset.
module tb_weightbuffer_ctrl;

  logic            clk_i;
  logic            rst_i;
  logic            start_i;
  logic [2:0]      num_o_i;
  logic            wvalid_i;
  logic            wready_o;
  logic [1:0][3:0] save_enable_o;
  logic [1:0]      flush_o;
  logic            compute_bank_o;
  logic            compute_release_i;
  logic            flush_req_i;
  logic            load_done_o;
  logic            err_o;
  logic            busy_o;

  int checks = 0;
  int errors = 0;

  weightbuffer_ctrl #(.N_O(4)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .start_i           (start_i),
    .num_o_i           (num_o_i),
    .wvalid_i          (wvalid_i),
    .wready_o          (wready_o),
    .save_enable_o     (save_enable_o),
    .flush_o           (flush_o),
    .compute_bank_o    (compute_bank_o),
    .compute_release_i (compute_release_i),
    .flush_req_i       (flush_req_i),
    .load_done_o       (load_done_o),
    .err_o             (err_o),
    .busy_o            (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic [2:0] n, input logic wv,
                               input logic rel, input logic fr);
    start_i           = s;
    num_o_i           = n;
    wvalid_i          = wv;
    compute_release_i = rel;
    flush_req_i       = fr;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Save enables are compared as {bank1, bank0}.
  task automatic checkOutput(input string tag, input logic wr, input logic [7:0] se,
                             input logic [1:0] fl, input logic done, input logic err,
                             input logic bank, input logic busy);
    #1;
    chk({tag, ".wready"},    8'(wready_o),       8'(wr));
    chk({tag, ".save"},      save_enable_o,      se);
    chk({tag, ".flush"},     8'(flush_o),        8'(fl));
    chk({tag, ".load_done"}, 8'(load_done_o),    8'(done));
    chk({tag, ".err"},       8'(err_o),          8'(err));
    chk({tag, ".bank"},      8'(compute_bank_o), 8'(bank));
    chk({tag, ".busy"},      8'(busy_o),         8'(busy));
  endtask

  initial begin
    rst_i = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    #3;
    checkOutput("reset", 0, 8'h00, 2'b00, 0, 0, 0, 0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    checkOutput("idle0", 0, 8'h00, 2'b00, 0, 0, 0, 0);
    tick;
    checkOutput("idle1", 0, 8'h00, 2'b00, 0, 0, 0, 0);

    // First load: 3 blocks into bank 1, compute free so swap is immediate
    applyStimulus(1, 3, 1, 0, 0);
    checkOutput("t1_idle", 0, 8'h00, 2'b00, 0, 0, 0, 0);
    tick; applyStimulus(0, 0, 1, 0, 0);
    checkOutput("t1_clear", 0, 8'h00, 2'b10, 0, 0, 0, 1);
    tick; checkOutput("t1_beat0", 1, 8'h10, 2'b00, 0, 0, 0, 1);
    tick; checkOutput("t1_beat1", 1, 8'h20, 2'b00, 0, 0, 0, 1);
    tick; checkOutput("t1_beat2", 1, 8'h40, 2'b00, 0, 0, 0, 1);
    tick; checkOutput("t1_ready", 0, 8'h00, 2'b00, 1, 0, 0, 1);
    tick; applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t1_swap", 0, 8'h00, 2'b00, 0, 0, 1, 0);

    // Second load: 4 blocks into bank 0, compute still busy so READY holds
    applyStimulus(1, 4, 1, 0, 0);
    checkOutput("t2_idle", 0, 8'h00, 2'b00, 0, 0, 1, 0);
    tick; applyStimulus(0, 0, 1, 0, 0);
    checkOutput("t2_clear", 0, 8'h00, 2'b01, 0, 0, 1, 1);
    tick; checkOutput("t2_beat0", 1, 8'h01, 2'b00, 0, 0, 1, 1);
    tick; checkOutput("t2_beat1", 1, 8'h02, 2'b00, 0, 0, 1, 1);
    tick; checkOutput("t2_beat2", 1, 8'h04, 2'b00, 0, 0, 1, 1);
    tick; checkOutput("t2_beat3", 1, 8'h08, 2'b00, 0, 0, 1, 1);
    tick; checkOutput("t2_ready", 0, 8'h00, 2'b00, 1, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      tick; checkOutput("t2_hold", 0, 8'h00, 2'b00, 0, 0, 1, 1);
    end
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("t2_release", 0, 8'h00, 2'b00, 0, 0, 1, 1);
    tick; applyStimulus(0, 0, 0, 1, 0);
    checkOutput("t2_swap", 0, 8'h00, 2'b00, 0, 0, 0, 0);
    tick; applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t2_idle2", 0, 8'h00, 2'b00, 0, 0, 0, 0);

    // Sparse beats into bank 1, then a flush after two beats
    applyStimulus(1, 4, 1, 0, 0);
    checkOutput("t3_idle", 0, 8'h00, 2'b00, 0, 0, 0, 0);
    tick; applyStimulus(0, 0, 1, 0, 0);
    checkOutput("t3_clear", 0, 8'h00, 2'b10, 0, 0, 0, 1);
    tick; checkOutput("t3_v1a", 1, 8'h10, 2'b00, 0, 0, 0, 1);
    tick; applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t3_v0a", 1, 8'h00, 2'b00, 0, 0, 0, 1);
    tick; checkOutput("t3_v0b", 1, 8'h00, 2'b00, 0, 0, 0, 1);
    tick; applyStimulus(0, 0, 1, 0, 0);
    checkOutput("t3_v1b", 1, 8'h20, 2'b00, 0, 0, 0, 1);
    tick; applyStimulus(0, 0, 1, 0, 1);
    checkOutput("t3_flushreq", 0, 8'h00, 2'b00, 0, 0, 0, 1);
    tick; applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t3_flush", 0, 8'h00, 2'b11, 0, 0, 0, 1);
    tick; checkOutput("t3_idle2", 0, 8'h00, 2'b00, 0, 0, 0, 0);

    // Held flush request repeats FLUSH
    applyStimulus(0, 0, 0, 0, 1);
    tick; checkOutput("t4_flush1", 0, 8'h00, 2'b11, 0, 0, 0, 1);
    tick; applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t4_flush2", 0, 8'h00, 2'b11, 0, 0, 0, 1);
    tick; checkOutput("t4_idle", 0, 8'h00, 2'b00, 0, 0, 0, 0);

    // Illegal channel counts
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("t5_start0", 0, 8'h00, 2'b00, 0, 0, 0, 0);
    tick; applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t5_err0", 0, 8'h00, 2'b00, 0, 1, 0, 0);
    tick; applyStimulus(1, 5, 0, 0, 0);
    checkOutput("t5_gap", 0, 8'h00, 2'b00, 0, 0, 0, 0);
    tick; applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t5_err5", 0, 8'h00, 2'b00, 0, 1, 0, 0);
    tick; checkOutput("t5_idle", 0, 8'h00, 2'b00, 0, 0, 0, 0);

    // Asynchronous reset while a beat is being accepted
    applyStimulus(1, 2, 1, 0, 0);
    tick; applyStimulus(0, 0, 1, 0, 0);
    checkOutput("t6_clear", 0, 8'h00, 2'b10, 0, 0, 0, 1);
    tick; checkOutput("t6_load", 1, 8'h10, 2'b00, 0, 0, 0, 1);
    rst_i = 1'b1;
    checkOutput("t6_reset", 0, 8'h00, 2'b00, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
